// File: rtl/ise_pkg.sv
// Shared definitions for the ISE pixel feeder.
// Holds the pixel and image-index widths, the per-image pixel limit and the
// feeder FSM state type.
package ise_pkg;

    localparam int unsigned PIXEL_W    = 24;
    localparam int unsigned IMG_IDX_W  = 5;
    localparam int unsigned MAX_PIXELS = 16384;
    // Wide enough to hold MAX_PIXELS-1 for any legal image size.
    localparam int unsigned PIX_CNT_W  = $clog2(MAX_PIXELS) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StSend
    } feeder_state_e;

endpackage

// File: rtl/ise_pixel_skid.sv
// One-entry skid buffer for pixel words.
// Catches read data that returns while the output stage is stalled, so that
// no in-flight memory word is lost.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture data_i (takes priority over drain_i)
//   drain_i       : the held word is consumed this cycle
//   data_i        : incoming pixel word
//   valid_o       : buffer holds a word
//   data_o        : held pixel word
module ise_pixel_skid
    import ise_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic [PIXEL_W-1:0] data_i,
    output logic               valid_o,
    output logic [PIXEL_W-1:0] data_o
);

    logic               valid_q, valid_d;
    logic [PIXEL_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ise_pixel_feeder.sv
// Streams every pixel of NUM_IMAGES images from a synchronous pixel memory to
// a sorting engine with a valid/busy handshake.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   start            : begin a run (sampled in IDLE only)
//   mem_rd, mem_addr : read strobe and address; data returns one cycle later
//   mem_rdata        : read data
//   busy             : engine stall; a pixel transfers when pixel_valid & !busy
//   pixel_valid      : pixel_out / image_index_out carry a pixel
//   pixel_out        : {R,G,B} pixel, zero when not valid
//   image_index_out  : image of the current pixel, held when not valid
//   done             : one-cycle pulse after the final pixel transfers
module ise_pixel_feeder
    import ise_pkg::*;
#(
    parameter int unsigned PIXELS_PER_IMAGE = 16384,
    parameter int unsigned NUM_IMAGES       = 32,
    parameter int unsigned ADDR_W           = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [PIXEL_W-1:0]   mem_rdata,
    input  logic                 busy,
    output logic                 pixel_valid,
    output logic [PIXEL_W-1:0]   pixel_out,
    output logic [IMG_IDX_W-1:0] image_index_out,
    output logic                 done
);

    // One extra bit so the read counter can reach the total without wrapping.
    localparam logic [ADDR_W:0]      TOTAL    = (ADDR_W+1)'(PIXELS_PER_IMAGE * NUM_IMAGES);
    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(PIXELS_PER_IMAGE - 1);
    localparam logic [IMG_IDX_W-1:0] LAST_IMG = IMG_IDX_W'(NUM_IMAGES - 1);

    feeder_state_e        state_q, state_d;
    logic [ADDR_W:0]      rd_addr_q, rd_addr_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 out_valid_q, out_valid_d;
    logic [PIXEL_W-1:0]   out_pix_q, out_pix_d;
    logic [IMG_IDX_W-1:0] out_idx_q, out_idx_d;
    logic                 out_last_q, out_last_d;
    logic [PIX_CNT_W-1:0] ld_pix_q, ld_pix_d;
    logic [IMG_IDX_W-1:0] ld_img_q, ld_img_d;
    logic                 done_q, done_d;

    logic               skid_valid;
    logic [PIXEL_W-1:0] skid_data;
    logic               accept, out_free, room, skid_load, skid_drain;
    logic [1:0]         occ;

    assign accept   = out_valid_q & ~busy;
    assign out_free = ~out_valid_q | accept;
    // Words held or in flight; a new read is allowed only if the output
    // register plus the skid entry can still absorb it after this edge.
    assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid} + {1'b0, rd_vld_q};
    assign room     = (occ < 2'd2) | ((occ == 2'd2) & accept);
    assign skid_load  = rd_vld_q & (~out_free | skid_valid);
    assign skid_drain = out_free & skid_valid;

    ise_pixel_skid u_skid (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .data_i  (mem_rdata),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        mem_rd      = 1'b0;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        ld_pix_d    = ld_pix_q;
        ld_img_d    = ld_img_q;
        done_d      = 1'b0;

        // Output stage: the skid entry is older than the word arriving now.
        if (out_free) begin
            out_valid_d = skid_valid | rd_vld_q;
            if (skid_valid | rd_vld_q) begin
                out_pix_d  = skid_valid ? skid_data : mem_rdata;
                out_idx_d  = ld_img_q;
                out_last_d = (ld_pix_q == LAST_PIX) && (ld_img_q == LAST_IMG);
                if (ld_pix_q == LAST_PIX) begin
                    ld_pix_d = '0;
                    ld_img_d = ld_img_q + IMG_IDX_W'(1);
                end else begin
                    ld_pix_d = ld_pix_q + PIX_CNT_W'(1);
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                // done_q marks the cycle right after a run ends.
                if (start && !done_q) begin
                    state_d    = StPrime;
                    rd_addr_d  = '0;
                    ld_pix_d   = '0;
                    ld_img_d   = '0;
                    out_last_d = 1'b0;
                end
            end
            StPrime: begin
                mem_rd  = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                mem_rd = (rd_addr_q < TOTAL) && room;
                if (accept && out_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (mem_rd) begin
            rd_addr_d = rd_addr_q + (ADDR_W+1)'(1);
        end
        rd_vld_d = mem_rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rd_addr_q   <= '0;
            rd_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            ld_pix_q    <= '0;
            ld_img_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_vld_q    <= rd_vld_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            ld_pix_q    <= ld_pix_d;
            ld_img_q    <= ld_img_d;
            done_q      <= done_d;
        end
    end

    assign mem_addr        = mem_rd ? rd_addr_q[ADDR_W-1:0] : '0;
    assign pixel_valid     = out_valid_q;
    assign pixel_out       = out_valid_q ? out_pix_q : '0;
    assign image_index_out = out_idx_q;
    assign done            = done_q;

endmodule

// File: tb/tb_ise_pixel_feeder.sv
// Directed bench for ise_pixel_feeder: a 4x2 instance and a 1x1 instance,
// each backed by a memory model returning 24'h0A0000 + address.
module tb_ise_pixel_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic        mem_rd;
    logic [18:0] mem_addr;
    logic [23:0] mem_rdata = '0;
    logic        pixel_valid;
    logic [23:0] pixel_out;
    logic [4:0]  image_index_out;
    logic        done;

    logic        s_start = 1'b0;
    logic        s_busy = 1'b0;
    logic        s_mem_rd;
    logic [18:0] s_mem_addr;
    logic [23:0] s_mem_rdata = '0;
    logic        s_pixel_valid;
    logic [23:0] s_pixel_out;
    logic [4:0]  s_image_index_out;
    logic        s_done;

    int checks = 0;
    int passes = 0;

    logic [23:0] acc_pix[$];
    logic [4:0]  acc_idx[$];
    int          done_cnt = 0;
    int          max_addr = 0;
    logic        mon_clr = 1'b0;

    always #5 clk = ~clk;

    ise_pixel_feeder #(
        .PIXELS_PER_IMAGE (4),
        .NUM_IMAGES       (2),
        .ADDR_W           (19)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .pixel_valid     (pixel_valid),
        .pixel_out       (pixel_out),
        .image_index_out (image_index_out),
        .done            (done)
    );

    ise_pixel_feeder #(
        .PIXELS_PER_IMAGE (1),
        .NUM_IMAGES       (1),
        .ADDR_W           (19)
    ) dut_small (
        .clk             (clk),
        .reset           (reset),
        .start           (s_start),
        .mem_rd          (s_mem_rd),
        .mem_addr        (s_mem_addr),
        .mem_rdata       (s_mem_rdata),
        .busy            (s_busy),
        .pixel_valid     (s_pixel_valid),
        .pixel_out       (s_pixel_out),
        .image_index_out (s_image_index_out),
        .done            (s_done)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= 24'h0A0000 + 24'(mem_addr);
        if (s_mem_rd) s_mem_rdata <= 24'h0A0000 + 24'(s_mem_addr);
    end

    // Inputs only change 1 time unit after a rising edge, so what is seen on
    // the falling edge is what the next rising edge will act on.
    always @(negedge clk) begin
        if (mon_clr) begin
            acc_pix.delete();
            acc_idx.delete();
            done_cnt = 0;
            max_addr = 0;
        end else begin
            if (pixel_valid && !busy) begin
                acc_pix.push_back(pixel_out);
                acc_idx.push_back(image_index_out);
            end
            if (done) done_cnt = done_cnt + 1;
            if (mem_rd && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b want 0", mem_rd); else passes++;
        checks++; if (mem_addr !== 19'd0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passes++;
        checks++; if (pixel_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", pixel_valid); else passes++;
        checks++; if (pixel_out !== 24'd0) $display("FAIL rst_pixel: got %h want 0", pixel_out); else passes++;
        checks++; if (image_index_out !== 5'd0) $display("FAIL rst_index: got %0d want 0", image_index_out); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passes++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_stream();
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (mem_rd !== 1'b1) $display("FAIL prime_rd: got %b want 1", mem_rd); else passes++;
        checks++; if (mem_addr !== 19'd0) $display("FAIL prime_addr: got %h want 0", mem_addr); else passes++;
        checks++; if (pixel_valid !== 1'b0) $display("FAIL prime_valid: got %b want 0", pixel_valid); else passes++;
        step();
        checks++; if (pixel_valid !== 1'b0) $display("FAIL lat1_valid: got %b want 0", pixel_valid); else passes++;
        step();
        for (int i = 0; i < 8; i++) begin
            logic [23:0] ep;
            logic [4:0]  ei;
            ep = 24'h0A0000 + 24'(i);
            ei = 5'(i / 4);
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== ep || image_index_out !== ei || done !== 1'b0)
                $display("FAIL stream_px%0d: got v=%b p=%h i=%0d d=%b want v=1 p=%h i=%0d d=0",
                         i, pixel_valid, pixel_out, image_index_out, done, ep, ei);
            else passes++;
            step();
        end
        checks++; if (done !== 1'b1) $display("FAIL stream_done: got %b want 1", done); else passes++;
        checks++;
        if (pixel_valid !== 1'b0 || pixel_out !== 24'd0 || image_index_out !== 5'd1)
            $display("FAIL stream_idle_out: got v=%b p=%h i=%0d want v=0 p=0 i=1",
                     pixel_valid, pixel_out, image_index_out);
        else passes++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL stream_done_cnt: got %0d want 1", done_cnt); else passes++;
        checks++; if (acc_pix.size() !== 8) $display("FAIL stream_accepts: got %0d want 8", acc_pix.size()); else passes++;
    endtask

    task automatic test_busy_stall();
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== 24'h0A0002 || image_index_out !== 5'd0)
                $display("FAIL stall_hold%0d: got v=%b p=%h i=%0d want v=1 p=0a0002 i=0",
                         k, pixel_valid, pixel_out, image_index_out);
            else passes++;
            if (k > 0) begin
                checks++; if (mem_rd !== 1'b0) $display("FAIL stall_rd%0d: got %b want 0", k, mem_rd); else passes++;
            end
            step();
        end
        busy = 1'b0;
        for (int j = 2; j < 8; j++) begin
            logic [23:0] ep;
            ep = 24'h0A0000 + 24'(j);
            checks++;
            if (pixel_valid !== 1'b1 || pixel_out !== ep || image_index_out !== 5'(j / 4))
                $display("FAIL stall_resume%0d: got v=%b p=%h i=%0d want v=1 p=%h i=%0d",
                         j, pixel_valid, pixel_out, image_index_out, ep, j / 4);
            else passes++;
            step();
        end
        checks++; if (done !== 1'b1) $display("FAIL stall_done: got %b want 1", done); else passes++;
        step();
        checks++; if (done_cnt !== 1) $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); else passes++;
        checks++; if (acc_pix.size() !== 8) $display("FAIL stall_accepts: got %0d want 8", acc_pix.size()); else passes++;
        for (int n = 0; n < 8 && n < acc_pix.size(); n++) begin
            checks++;
            if (acc_pix[n] !== 24'h0A0000 + 24'(n))
                $display("FAIL stall_order%0d: got %h want %h", n, acc_pix[n], 24'h0A0000 + 24'(n));
            else passes++;
        end
    endtask

    task automatic test_busy_toggle();
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 80 && done_cnt == 0; c++) begin
            busy = c[0];
            step();
        end
        busy = 1'b0;
        step();
        checks++; if (done_cnt !== 1) $display("FAIL toggle_done_cnt: got %0d want 1", done_cnt); else passes++;
        checks++; if (acc_pix.size() !== 8) $display("FAIL toggle_accepts: got %0d want 8", acc_pix.size()); else passes++;
        for (int n = 0; n < 8 && n < acc_pix.size(); n++) begin
            checks++;
            if (acc_pix[n] !== 24'h0A0000 + 24'(n) || acc_idx[n] !== 5'(n / 4))
                $display("FAIL toggle_order%0d: got p=%h i=%0d want p=%h i=%0d",
                         n, acc_pix[n], acc_idx[n], 24'h0A0000 + 24'(n), n / 4);
            else passes++;
        end
        checks++; if (max_addr > 7) $display("FAIL toggle_max_addr: got %0d want <=7", max_addr); else passes++;
    endtask

    task automatic test_reset_mid_run();
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && acc_pix.size() < 5; c++) step();
        checks++; if (acc_pix.size() !== 5) $display("FAIL midrst_reach5: got %0d want 5", acc_pix.size()); else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || mem_addr !== 19'd0 || done !== 1'b0)
            $display("FAIL midrst_mem: got rd=%b a=%h d=%b want 0 0 0", mem_rd, mem_addr, done);
        else passes++;
        checks++;
        if (pixel_valid !== 1'b0 || pixel_out !== 24'd0 || image_index_out !== 5'd0)
            $display("FAIL midrst_out: got v=%b p=%h i=%0d want 0 0 0", pixel_valid, pixel_out, image_index_out);
        else passes++;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (pixel_valid !== 1'b0 || mem_rd !== 1'b0)
            $display("FAIL midrst_wait: got v=%b rd=%b want 0 0", pixel_valid, mem_rd);
        else passes++;
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (pixel_valid !== 1'b1 || pixel_out !== 24'h0A0000 || image_index_out !== 5'd0)
            $display("FAIL midrst_restart: got v=%b p=%h i=%0d want v=1 p=0a0000 i=0",
                     pixel_valid, pixel_out, image_index_out);
        else passes++;
        for (int c = 0; c < 40 && done_cnt == 0; c++) step();
        step();
        checks++; if (acc_pix.size() !== 8) $display("FAIL midrst_accepts: got %0d want 8", acc_pix.size()); else passes++;
    endtask

    task automatic test_start_ignored();
        int c;
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        step();
        step();
        start = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            step();
            c++;
        end
        checks++; if (done !== 1'b1) $display("FAIL ign_done_seen: got %b want 1", done); else passes++;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (mem_rd !== 1'b0) $display("FAIL ign_start_at_done: got rd=%b want 0", mem_rd); else passes++;
        step();
        step();
        checks++; if (pixel_valid !== 1'b0) $display("FAIL ign_no_rerun: got %b want 0", pixel_valid); else passes++;
        checks++; if (acc_pix.size() !== 8) $display("FAIL ign_accepts: got %0d want 8", acc_pix.size()); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); else passes++;
    endtask

    task automatic test_single_pixel();
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        checks++;
        if (s_mem_rd !== 1'b1 || s_mem_addr !== 19'd0)
            $display("FAIL single_prime: got rd=%b a=%h want 1 0", s_mem_rd, s_mem_addr);
        else passes++;
        step();
        checks++; if (s_pixel_valid !== 1'b0) $display("FAIL single_lat: got %b want 0", s_pixel_valid); else passes++;
        step();
        checks++;
        if (s_pixel_valid !== 1'b1 || s_pixel_out !== 24'h0A0000 || s_image_index_out !== 5'd0 || s_done !== 1'b0)
            $display("FAIL single_px: got v=%b p=%h i=%0d d=%b want 1 0a0000 0 0",
                     s_pixel_valid, s_pixel_out, s_image_index_out, s_done);
        else passes++;
        step();
        checks++;
        if (s_done !== 1'b1 || s_pixel_valid !== 1'b0)
            $display("FAIL single_done: got d=%b v=%b want 1 0", s_done, s_pixel_valid);
        else passes++;
        step();
        checks++;
        if (s_done !== 1'b0 || s_pixel_valid !== 1'b0 || s_mem_rd !== 1'b0)
            $display("FAIL single_after: got d=%b v=%b rd=%b want 0 0 0", s_done, s_pixel_valid, s_mem_rd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_busy_stall();
        test_busy_toggle();
        test_reset_mid_run();
        test_start_ignored();
        test_single_pixel();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/ise_pixel_feeder.md
ISE_PIXEL_FEEDER -- requirements
Module: ise_pixel_feeder

Interface
REQ-001 Parameters SHALL be:
- PIXELS_PER_IMAGE, 16384, pixels per image; legal range 1..16384.
- NUM_IMAGES, 32, images per run; legal range 1..32.
- ADDR_W, 19, memory address width; at least clog2(PIXELS_PER_IMAGE*NUM_IMAGES).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- mem_rd  out  1  synchronous pixel-memory read strobe.
- mem_addr  out  ADDR_W  read address (image*PIXELS_PER_IMAGE + pixel).
- mem_rdata  in  24  read data, valid exactly 1 cycle after mem_rd.
- busy  in  1  sorting-engine busy; a pixel is accepted only when busy=0.
- pixel_valid  out  1  pixel_out/image_index_out hold a pixel for transfer.
- pixel_out  out  24  pixel {R,G,B}, 8 bits each, R in [23:16].
- image_index_out  out  5  index of the image the current pixel belongs to.
- done  out  1  one-cycle pulse when the last pixel of the last image is accepted.

Function
REQ-003 Transfer rule: a pixel SHALL be accepted on a rising edge where pixel_valid=1 and busy=0.
REQ-004 The block SHALL present the pixels of image 0, then 1, ..., NUM_IMAGES-1, each in ascending pixel order. image_index_out SHALL be constant within an image.
REQ-005 No pixel SHALL be lost, duplicated or reordered under any busy pattern.
REQ-006 The FSM SHALL have three states: IDLE, PRIME, SEND.
- IDLE -> PRIME when start=1.
- PRIME -> SEND unconditionally.
- SEND -> IDLE on acceptance of the final pixel.
REQ-007 In PRIME, mem_rd=1 and mem_addr=0. The first pixel_valid=1 SHALL appear 2 cycles after the edge that samples start.
REQ-008 In SEND with busy=0 continuously, throughput SHALL be one pixel per clock. mem_rd SHALL be issued every cycle in which the next address is required.
REQ-009 busy asserted while a read is in flight: the returned mem_rdata SHALL be captured in a one-entry hold register. The hold register SHALL be drained first when busy falls.
REQ-010 While busy=1: mem_rd=0 after at most one cycle, and pixel_out and image_index_out SHALL hold stable.
REQ-011 When pixel_valid=0: pixel_out=24'd0, and image_index_out SHALL hold its last value (0 after reset).
REQ-012 Index wrap: after pixel PIXELS_PER_IMAGE-1 of image k, the next pixel SHALL be pixel 0 of image k+1. mem_addr SHALL never exceed PIXELS_PER_IMAGE*NUM_IMAGES-1.
REQ-013 done SHALL be 1 for exactly the cycle after the final acceptance. pixel_valid=0 in that cycle.
REQ-014 start asserted outside IDLE SHALL be ignored. start and done coinciding SHALL NOT begin a new run that cycle.
REQ-015 Corner case PIXELS_PER_IMAGE=1, NUM_IMAGES=1: exactly one pixel SHALL be transferred, followed by done.

Reset
REQ-016 reset=0 SHALL asynchronously force: state IDLE, all counters 0, hold register empty, and all outputs 0 (mem_rd, mem_addr, pixel_valid, pixel_out, image_index_out, done).
REQ-017 Reset asserted mid-run SHALL abandon the run. After release, the block SHALL wait for a new start, and the next run SHALL begin at image 0, pixel 0.

Structure
REQ-018 Shared package ise_pkg SHALL hold: PIXEL_W=24, IMG_IDX_W=5, the feeder state enum, and the max-pixel constant 16384.
REQ-019 The hold register and its valid flag SHALL be one sub-module, ise_pixel_skid (1-entry skid buffer). Address generation and the FSM SHALL stay in ise_pixel_feeder.

Verification (PIXELS_PER_IMAGE=4, NUM_IMAGES=2, memory word at address a = 24'h0A0000+a, unless noted)
REQ-020 start pulse, busy=0 throughout -> 8 accepts in 8 consecutive cycles starting 2 cycles after start, with pixel_out 0A0000..0A0007, image_index_out 0,0,0,0,1,1,1,1, then a single done pulse.
REQ-021 busy=1 for 3 cycles starting on the cycle the 3rd pixel is first valid -> 3rd pixel 0A0002 held stable for those 3 cycles, then sequence resumes 0A0002, 0A0003..0A0007 with no gaps, no duplicates, done once.
REQ-022 busy toggling 1/0 every cycle -> all 8 pixels accepted exactly once in order; mem_addr never exceeds 7.
REQ-023 reset=0 asserted after the 5th accept, released, start again -> outputs 0 during reset, and the second run starts at pixel 0A0000, image 0.
REQ-024 start pulsed again during SEND, and PIXELS_PER_IMAGE=1, NUM_IMAGES=1 run -> mid-run start has no effect; single-pixel run yields one accept, then done.
